main_ctrl: RTL

MAIN_CTRL -- requirements
Module: main_ctrl

---
 rtl/main_ctrl_pkg.sv | 78 +++++++
 rtl/main_ctrl_decode.sv | 75 +++++++
 rtl/main_ctrl.sv | 76 +++++++
 3 files changed

// File: rtl/main_ctrl_pkg.sv
// main_ctrl_pkg -- shared encodings for the multicycle MIPS control path (rev 1.0)
`default_nettype none

package main_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_MEMADR  = 4'd2,
    ST_MEMRD   = 4'd3,
    ST_MEMWB   = 4'd4,
    ST_MEMWR   = 4'd5,
    ST_RTYPEEX = 4'd6,
    ST_RTYPEWB = 4'd7,
    ST_BEQEX   = 4'd8,
    ST_ADDIEX  = 4'd9,
    ST_ADDIWB  = 4'd10,
    ST_JEX     = 4'd11,
    ST_JREX    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FUNC_JR  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REGA   = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // Instruction dispatch out of DECODE; unrecognised opcodes retire as no-ops.
  function automatic state_t dispatch(input logic [5:0] opcode, input logic [5:0] func);
    state_t nxt;
    case (opcode)
      OP_LW, OP_SW: nxt = ST_MEMADR;
      OP_RTYPE:     nxt = (func == FUNC_JR) ? ST_JREX : ST_RTYPEEX;
      OP_BEQ:       nxt = ST_BEQEX;
      OP_ADDI:      nxt = ST_ADDIEX;
      OP_J:         nxt = ST_JEX;
      default:      nxt = ST_FETCH;
    endcase
    return nxt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/main_ctrl_decode.sv
// main_ctrl_decode -- combinational state-to-control-word decode (rev 1.0)
`default_nettype none

module main_ctrl_decode
  import main_ctrl_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = CTRL_IDLE;
    case (state)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.pc_write  = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
      end
      ST_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ST_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      ST_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.ior_d    = 1'b1;
      end
      ST_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      ST_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.ior_d     = 1'b1;
      end
      ST_RTYPEEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_FUNC;
      end
      ST_RTYPEWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      ST_BEQEX: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      ST_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      ST_ADDIWB: ctrl.reg_write = 1'b1;
      ST_JEX: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      ST_JREX: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_REGA;
      end
      default: ctrl = CTRL_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/main_ctrl.sv
// main_ctrl -- multicycle MIPS main control FSM: state register, next-state logic, decode (rev 1.0)
`default_nettype none

module main_ctrl
  import main_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic       memToReg,
  output logic       regDst,
  output logic       regWrite,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOP,
  output logic [1:0] pcSource,
  output logic [3:0] state
);

  state_t cur_state;
  state_t nxt_state;
  ctrl_t  dec_ctrl;
  ctrl_t  ctrl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur_state <= ST_FETCH;
    else     cur_state <= nxt_state;
  end

  // opcode/func are only looked at in DECODE and MEMADR so the IR may change freely elsewhere.
  always_comb begin
    nxt_state = ST_FETCH;
    case (cur_state)
      ST_FETCH:   nxt_state = ST_DECODE;
      ST_DECODE:  nxt_state = dispatch(opcode, func);
      ST_MEMADR:  nxt_state = (opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
      ST_MEMRD:   nxt_state = ST_MEMWB;
      ST_RTYPEEX: nxt_state = ST_RTYPEWB;
      ST_ADDIEX:  nxt_state = ST_ADDIWB;
      default:    nxt_state = ST_FETCH;
    endcase
  end

  main_ctrl_decode u_decode (
    .state (cur_state),
    .ctrl  (dec_ctrl)
  );

  // Reset holds the FSM in FETCH, whose strobes must not reach the datapath until rst falls.
  assign ctrl = rst ? CTRL_IDLE : dec_ctrl;

  assign pcWrite     = ctrl.pc_write;
  assign pcWriteCond = ctrl.pc_write_cond;
  assign iorD        = ctrl.ior_d;
  assign memRead     = ctrl.mem_read;
  assign memWrite    = ctrl.mem_write;
  assign irWrite     = ctrl.ir_write;
  assign memToReg    = ctrl.mem_to_reg;
  assign regDst      = ctrl.reg_dst;
  assign regWrite    = ctrl.reg_write;
  assign aluSrcA     = ctrl.alu_src_a;
  assign aluSrcB     = ctrl.alu_src_b;
  assign aluOP       = ctrl.alu_op;
  assign pcSource    = ctrl.pc_source;
  assign state       = cur_state;

endmodule

`default_nettype wire
